mhp_task_scheduler: RTL

MHP_TASK_SCHEDULER -- requirements
Module: mhp_task_scheduler

---
 rtl/mhp_task_scheduler.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mhp_task_scheduler.sv
// mhp_task_scheduler: queues per-channel task requests, links up the protocol engine, and dispatches queued tasks as typed sends, granting addresses on completion.
// Latency: a request is pushed on the sampling edge and acked the next cycle; a pop in LINKED raises o_send the next cycle; the grant follows i_done by one edge.
// Backpressure: requests are held until acked, and none is accepted while o_full; tasks are popped only in LINKED while no send is outstanding.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_task_start / i_task_nbr      per-channel request and 16-bit task number (channel k at [16k+15:16k])
//   o_task_ack                     one-hot accept pulse, one cycle after the push
//   i_done, i_rx_dst, i_rx_src     protocol engine completion pulse and returned addresses
//   o_send, o_link, o_dtype        protocol engine controls
//   o_grant, o_grant_ch,
//   o_dest_addr, o_src_addr        address grant; addresses hold until the next grant
//   o_err_task, o_timeout,
//   o_full, o_empty                status
//
// Build option: define MHP_TASK_TIMEOUT_EN to abandon a TX_WAIT that sees no i_done within TIMEOUT_CYC cycles.
module mhp_task_scheduler #(
   parameter int NUM_CH      = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_CH-1:0]    i_task_start,
   input  logic [NUM_CH*16-1:0] i_task_nbr,
   output logic [NUM_CH-1:0]    o_task_ack,
   input  logic                 i_done,
   input  logic [15:0]          i_rx_dst,
   input  logic [15:0]          i_rx_src,
   output logic                 o_send,
   output logic                 o_link,
   output logic [7:0]           o_dtype,
   output logic                 o_grant,
   output logic [2:0]           o_grant_ch,
   output logic [15:0]          o_dest_addr,
   output logic [15:0]          o_src_addr,
   output logic                 o_err_task,
   output logic                 o_timeout,
   output logic                 o_full,
   output logic                 o_empty
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [2:0]  ch;
      logic [15:0] nbr;
   } entry_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CONNECTED = 3'd1,
      LINKED    = 3'd2,
      TX_SEND   = 3'd3,
      TX_WAIT   = 3'd4
   } state_t;

   state_t state_q, state_d;

   // ------------------------------------------------------------------
   // Task queue
   // ------------------------------------------------------------------
   entry_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   entry_t             head;
   entry_t             push_entry;
   logic               push;
   logic               pop;

   assign o_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign o_empty = (count_q == '0);
   assign head    = mem[rd_ptr_q];

   // ------------------------------------------------------------------
   // Round-robin request selection
   // ------------------------------------------------------------------
   logic [2:0]        rr_q;
   logic [NUM_CH-1:0] req;
   logic              pick_vld;
   logic [2:0]        pick_ch;

   // A channel whose ack is on the wire this cycle may still show its
   // request; masking it stops the same request being queued twice.
   assign req = i_task_start & ~o_task_ack;

   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick_ch  = 3'd0;
      idx      = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(rr_q) + i) % NUM_CH;
         if (!pick_vld && req[idx]) begin
            pick_vld = 1'b1;
            pick_ch  = 3'(idx);
         end
      end
   end

   // A full queue refuses the push even when a pop happens on the same edge.
   assign push       = pick_vld && !o_full;
   assign push_entry = '{ch: pick_ch, nbr: i_task_nbr[{pick_ch, 4'h0} +: 16]};

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_entry;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rr_q       <= 3'd0;
         o_task_ack <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rr_q     <= (pick_ch == 3'(NUM_CH - 1)) ? 3'd0 : pick_ch + 3'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
         o_task_ack <= push ? (NUM_CH'(1) << pick_ch) : '0;
      end
   end

   // ------------------------------------------------------------------
   // Task type decode (low byte of the task number)
   // ------------------------------------------------------------------
   logic [6:0] code;
   logic       code_vld;
   logic       unused_nbr_hi;

   assign unused_nbr_hi = ^head.nbr[15:8];

   always_comb begin
      code     = 7'h00;
      code_vld = 1'b1;
      case (head.nbr[7:0])
         8'h10:   code = 7'h03;
         8'h20:   code = 7'h01;
         8'h30:   code = 7'h05;
         default: code_vld = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Link / dispatch FSM
   // ------------------------------------------------------------------
   logic [2:0]  cur_ch_q, cur_ch_d;
   logic        send_d;
   logic        err_d;
   logic        grant_d;
   logic [2:0]  grant_ch_d;
   logic [7:0]  dtype_d;
   logic [15:0] dest_d;
   logic [15:0] src_d;

`ifdef MHP_TASK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] wait_cnt_q;
   logic            timeout_d;
`endif

   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      send_d     = 1'b0;
      err_d      = 1'b0;
      grant_d    = 1'b0;
      grant_ch_d = o_grant_ch;
      dtype_d    = o_dtype;
      dest_d     = o_dest_addr;
      src_d      = o_src_addr;
      cur_ch_d   = cur_ch_q;
`ifdef MHP_TASK_TIMEOUT_EN
      timeout_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (i_done) begin
               send_d  = 1'b1;
               state_d = CONNECTED;
            end
         end
         CONNECTED: begin
            if (i_done) begin
               state_d = LINKED;
            end
         end
         LINKED: begin
            // A fresh i_done means the engine re-connected: restart the link.
            if (i_done) begin
               send_d  = 1'b1;
               state_d = CONNECTED;
            end else if (!o_empty) begin
               pop = 1'b1;
               if (code_vld) begin
                  dtype_d  = {1'b1, code};
                  send_d   = 1'b1;
                  cur_ch_d = head.ch;
                  state_d  = TX_SEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         TX_SEND: begin
            state_d = TX_WAIT;
         end
         TX_WAIT: begin
            if (i_done) begin
               grant_d    = 1'b1;
               grant_ch_d = cur_ch_q;
               dest_d     = i_rx_dst;
               src_d      = i_rx_src;
               state_d    = LINKED;
            end
`ifdef MHP_TASK_TIMEOUT_EN
            else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_link = (state_q == LINKED) || (state_q == TX_SEND) || (state_q == TX_WAIT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         cur_ch_q    <= 3'd0;
         o_send      <= 1'b0;
         o_err_task  <= 1'b0;
         o_grant     <= 1'b0;
         o_grant_ch  <= 3'd0;
         o_dtype     <= 8'h00;
         o_dest_addr <= 16'h0000;
         o_src_addr  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         o_send      <= send_d;
         o_err_task  <= err_d;
         o_grant     <= grant_d;
         o_grant_ch  <= grant_ch_d;
         o_dtype     <= dtype_d;
         o_dest_addr <= dest_d;
         o_src_addr  <= src_d;
      end
   end

`ifdef MHP_TASK_TIMEOUT_EN
   // Counts completed TX_WAIT cycles; cleared whenever the FSM is elsewhere.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_cnt_q <= '0;
         o_timeout  <= 1'b0;
      end else begin
         o_timeout <= timeout_d;
         if (state_q == TX_WAIT && state_d == TX_WAIT) begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
         end else begin
            wait_cnt_q <= '0;
         end
      end
   end
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
   assign o_timeout          = 1'b0;
`endif

endmodule
